// File: rtl/div_seq_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient} = {HI, LO}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes straight from the capture cycle.
module div_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    output logic                 stall,
    output logic [2*WIDTH-1:0]   result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  quo_q;
    logic [WIDTH-1:0]  div_mag;
    logic [WIDTH-1:0]  raw_dividend;
    logic              q_sign;
    logic              r_sign;
    logic              div_zero;

    logic              capture;
    logic [WIDTH-1:0]  dividend_abs;
    logic [WIDTH-1:0]  divisor_abs;
    logic [WIDTH:0]    rem_shift;
    logic [WIDTH:0]    rem_diff;
    logic              rem_ge;
    logic [WIDTH-1:0]  rem_next;
    logic [WIDTH-1:0]  quo_next;
    logic [2*WIDTH-1:0] final_result;

    // The shifted partial remainder needs one extra bit so the compare never overflows.
    always_comb begin
        capture      = (state == IDLE) && start && !annul;
        stall        = !rst && !annul && (((state == IDLE) && start) || (state == BUSY));
        dividend_abs = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_abs  = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
        rem_shift    = {rem_q, quo_q[WIDTH-1]};
        rem_diff     = rem_shift - {1'b0, div_mag};
        rem_ge       = (rem_shift >= {1'b0, div_mag});
        rem_next     = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next     = {quo_q[WIDTH-2:0], rem_ge};
        if (div_zero) begin
            final_result = {raw_dividend, {WIDTH{1'b1}}};
        end else begin
            final_result = {(r_sign ? -rem_next : rem_next),
                            (q_sign ? -quo_next : quo_next)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            div_mag      <= '0;
            raw_dividend <= '0;
            q_sign       <= 1'b0;
            r_sign       <= 1'b0;
            div_zero     <= 1'b0;
            result       <= '0;
        end else if (annul) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        rem_q        <= '0;
                        quo_q        <= dividend_abs;
                        div_mag      <= divisor_abs;
                        raw_dividend <= dividend;
                        q_sign       <= signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_sign       <= signed_div && dividend[WIDTH-1];
                        div_zero     <= (divisor == '0);
                        count        <= '0;
`ifdef DIV_ZERO_FAST_EN
                        if (divisor == '0) begin
                            result <= {dividend, {WIDTH{1'b1}}};
                            state  <= DONE;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        result <= final_result;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit: directed corner cases plus random divides
// checked against a plain-arithmetic reference model.
module tb_div_seq_unit;

    localparam int WIDTH = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  dividend;
    logic [WIDTH-1:0]  divisor;
    logic              start;
    logic              signed_div;
    logic              annul;
    logic              stall;
    logic [2*WIDTH-1:0] result;

    int checks;
    int errors;

    div_seq_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .dividend   (dividend),
        .divisor    (divisor),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .stall      (stall),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: language division truncates toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa;
        longint sb;
        logic [31:0] qq;
        logic [31:0] rr;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        qq = 32'(sa / sb);
        rr = 32'(sa % sb);
        return {rr, qq};
    endfunction

    function automatic int expStall(input logic [31:0] b);
        if (b == 32'd0 && FAST_ZERO) return 1;
        return WIDTH + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        dividend   = a;
        divisor    = b;
        signed_div = sgn;
        start      = 1'b1;
    endtask

    // Runs one divide; leaves the DUT in DONE with start held when keep is set,
    // otherwise drops start and steps into IDLE.
    task automatic runDiv(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit sgn, input bit keep, input bit from_done);
        int cycles;
        logic [63:0] expected;
        expected = refDiv(a, b, sgn);
        applyStimulus(a, b, sgn);
        if (from_done) begin
            @(posedge clk);
        end
        #1;
        cycles = 0;
        while (stall === 1'b1 && cycles < 200) begin
            cycles++;
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_stall_cycles"}, 64'(cycles), 64'(expStall(b)));
        checkOutput({tag, "_result"}, result, expected);
        if (!keep) begin
            start = 1'b0;
            @(posedge clk);
            #1;
            checkOutput({tag, "_hold_idle"}, result, expected);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;
        logic [63:0] prior;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        start      = 1'b1;
        annul      = 1'b0;
        dividend   = 32'd7;
        divisor    = 32'd2;
        signed_div = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_stall", 64'(stall), 64'd0);
        checkOutput("reset_result", result, 64'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_stall", 64'(stall), 64'd0);

        runDiv("divu_7_2", 32'd7, 32'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("divu_7_2_const", result, {32'd1, 32'd3});
        runDiv("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("div_m7_2_const", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        runDiv("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        checkOutput("div_7_m2_const", result, {32'd1, 32'hFFFF_FFFD});
        runDiv("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        checkOutput("div_ovf_const", result, {32'd0, 32'h8000_0000});
        runDiv("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
        runDiv("divu_5_0", 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("divu_5_0_const", result, {32'd5, 32'hFFFF_FFFF});
        runDiv("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0, 1'b0);

        // Annul mid-BUSY: prior result must survive.
        runDiv("prior", 32'd7, 32'd2, 1'b0, 1'b0, 1'b0);
        prior = result;
        applyStimulus(32'd100, 32'd7, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        start = 1'b0;
        #1;
        checkOutput("annul_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        annul = 1'b0;
        #1;
        checkOutput("annul_idle_stall", 64'(stall), 64'd0);
        checkOutput("annul_result", result, prior);

        // Annul and start together in IDLE: no capture.
        start = 1'b1;
        annul = 1'b1;
        #1;
        checkOutput("annul_start_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        #1;
        checkOutput("annul_start_nocap", 64'(stall), 64'd0);

        // Reset mid-BUSY clears the result.
        applyStimulus(32'd100, 32'd7, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_busy_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("rst_busy_result", result, 64'd0);
        checkOutput("rst_busy_idle", 64'(stall), 64'd0);

        // Back-to-back with start held through DONE.
        runDiv("b2b_100_7", 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
        runDiv("b2b_9_3", 32'd9, 32'd3, 1'b0, 1'b0, 1'b1);
        checkOutput("b2b_9_3_const", result, {32'd0, 32'd3});

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            runDiv($sformatf("rand%0d", i), ra, rb, rs, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
